// File: rtl/ws2812_rx_if.sv
// Bundle between the WS2812 receiver and its consumer: the raw serial line
// in, decoded 24-bit words and frame/status pulses out.
interface ws2812_rx_if;
  logic        din;
  logic [23:0] rgb_data;
  logic [7:0]  led_num;
  logic        write;
  logic        frame_done;
  logic        error;
  logic        busy;

  modport master (
    input  din,
    output rgb_data, led_num, write, frame_done, error, busy
  );

  modport slave (
    output din,
    input  rgb_data, led_num, write, frame_done, error, busy
  );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 serial line decoder: measures high-pulse widths to recover bits and
// reassembles them into 24-bit words tagged with the LED they belong to.
module ws2812_rx #(
  parameter int NUM_LEDS   = 8,
  parameter int CLK_MHZ    = 12,
  parameter int T_THRESH   = CLK_MHZ * 600 / 1000,
  parameter int T_MIN      = 2,
  parameter int T_HIGH_MAX = CLK_MHZ * 5,
  parameter int T_RESET    = CLK_MHZ * 50
) (
  input logic         clk,
  input logic         reset,
  ws2812_rx_if.master bus
);

  localparam int CW = $clog2(T_RESET + 1);
  localparam logic [CW-1:0] ONE        = CW'(1);
  localparam logic [CW-1:0] RESET_LAST = CW'(T_RESET - 1);
  localparam logic [CW-1:0] HIGH_LAST  = CW'(T_HIGH_MAX - 1);
  localparam logic [CW-1:0] THRESH     = CW'(T_THRESH);
  localparam logic [CW-1:0] MIN_HIGH   = CW'(T_MIN);
  localparam logic [CW-1:0] LEDS       = CW'(NUM_LEDS);
  localparam logic [CW-1:0] BIT_LAST   = CW'(23);
  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [7:0]    LED_LAST   = 8'(NUM_LEDS - 1);

  typedef enum logic [1:0] {SYNC, ARMED, HIGH, LOW} state_t;

  state_t        state, state_n;
  logic          din_s1, din_s2, din_d;
  logic          rise, fall, bit_val;
  logic [CW-1:0] low_cnt, low_cnt_n;
  logic [CW-1:0] high_cnt, high_cnt_n;
  logic [CW-1:0] bit_cnt, bit_cnt_n;
  logic [CW-1:0] word_idx, word_idx_n;
  logic [22:0]   shift_reg, shift_n;
  logic [23:0]   word_in, rgb_n;
  logic [7:0]    led_n;
  logic          write_n, done_n, error_n;

  // Two-flop synchronizer plus a delayed copy of the second flop for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      din_s1 <= 1'b0;
      din_s2 <= 1'b0;
      din_d  <= 1'b0;
    end else begin
      din_s1 <= bus.din;
      din_s2 <= din_s1;
      din_d  <= din_s2;
    end
  end

  assign rise     = din_s2 & ~din_d;
  assign fall     = ~din_s2 & din_d;
  assign bit_val  = (high_cnt >= THRESH);
  assign word_in  = {shift_reg, bit_val};
  assign bus.busy = (state == HIGH) || (state == LOW);

  always_comb begin
    state_n    = state;
    low_cnt_n  = low_cnt;
    high_cnt_n = high_cnt;
    bit_cnt_n  = bit_cnt;
    word_idx_n = word_idx;
    shift_n    = shift_reg;
    rgb_n      = bus.rgb_data;
    led_n      = bus.led_num;
    write_n    = 1'b0;
    done_n     = 1'b0;
    error_n    = 1'b0;

    case (state)
      SYNC: begin
        bit_cnt_n  = '0;
        word_idx_n = '0;
        if (din_s2) begin
          low_cnt_n = '0;
        end else if (low_cnt == RESET_LAST) begin
          low_cnt_n = '0;
          state_n   = ARMED;
        end else begin
          low_cnt_n = low_cnt + ONE;
        end
      end

      ARMED: begin
        bit_cnt_n  = '0;
        word_idx_n = '0;
        if (rise) begin
          high_cnt_n = '0;
          state_n    = HIGH;
        end
      end

      HIGH: begin
        if (fall) begin
          if (high_cnt < MIN_HIGH) begin
            error_n    = 1'b1;
            low_cnt_n  = '0;
            bit_cnt_n  = '0;
            word_idx_n = '0;
            state_n    = SYNC;
          end else begin
            shift_n   = word_in[22:0];
            low_cnt_n = '0;
            state_n   = LOW;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt_n = '0;
              // Words past the last LED are dropped; only the first one flags an error.
              if (word_idx < LEDS) begin
                write_n = 1'b1;
                rgb_n   = word_in;
                led_n   = LED_LAST - 8'(word_idx);
              end else if (word_idx == LEDS) begin
                error_n = 1'b1;
              end
              if (word_idx != CNT_MAX) word_idx_n = word_idx + ONE;
            end else begin
              bit_cnt_n = bit_cnt + ONE;
            end
          end
        end else if (high_cnt == HIGH_LAST) begin
          high_cnt_n = high_cnt + ONE;
          error_n    = 1'b1;
          low_cnt_n  = '0;
          bit_cnt_n  = '0;
          word_idx_n = '0;
          state_n    = SYNC;
        end else begin
          high_cnt_n = high_cnt + ONE;
        end
      end

      LOW: begin
        if (rise) begin
          high_cnt_n = '0;
          state_n    = HIGH;
        end else if (low_cnt == RESET_LAST) begin
          // LOW is only reachable after a decoded bit, so every gap here closes a frame.
          done_n     = 1'b1;
          error_n    = (bit_cnt != '0);
          low_cnt_n  = '0;
          bit_cnt_n  = '0;
          word_idx_n = '0;
          state_n    = ARMED;
        end else begin
          low_cnt_n = low_cnt + ONE;
        end
      end

      default: state_n = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= SYNC;
      low_cnt        <= '0;
      high_cnt       <= '0;
      bit_cnt        <= '0;
      word_idx       <= '0;
      shift_reg      <= '0;
      bus.rgb_data   <= '0;
      bus.led_num    <= '0;
      bus.write      <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.error      <= 1'b0;
    end else begin
      state          <= state_n;
      low_cnt        <= low_cnt_n;
      high_cnt       <= high_cnt_n;
      bit_cnt        <= bit_cnt_n;
      word_idx       <= word_idx_n;
      shift_reg      <= shift_n;
      bus.rgb_data   <= rgb_n;
      bus.led_num    <= led_n;
      bus.write      <= write_n;
      bus.frame_done <= done_n;
      bus.error      <= error_n;
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// Self-checking bench for ws2812_rx: drives WS2812 waveforms and compares the
// logged write/error/frame_done pulses against a word-level frame model.
module tb_ws2812_rx;
  localparam int NUM_LEDS = 8;
  localparam int GAP      = 700;

  typedef struct {
    logic [23:0] data;
    logic [7:0]  led;
    int          cyc;
  } wr_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_fall_edge = 0;
  wr_t  wr_q[$];
  int   err_q[$];
  int   done_q[$];

  ws2812_rx_if bus ();

  ws2812_rx #(.NUM_LEDS(NUM_LEDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse logger, sampled on the falling edge well away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.write) wr_q.push_back('{data: bus.rgb_data, led: bus.led_num, cyc: cyc});
      if (bus.error) err_q.push_back(cyc);
      if (bus.frame_done) done_q.push_back(cyc);
    end
  end

  task automatic clear_logs();
    wr_q.delete();
    err_q.delete();
    done_q.delete();
  endtask

  task automatic drive(input logic v, input int n);
    @(negedge clk);
    bus.din = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int hi, input int lo);
    drive(1'b1, hi);
    @(negedge clk);
    bus.din = 1'b0;
    last_fall_edge = cyc + 1;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic send_word(input logic [23:0] w, input bit rnd);
    for (int i = 23; i >= 0; i--) begin
      if (rnd)
        send_bit(w[i], w[i] ? int'($urandom_range(14, 10)) : int'($urandom_range(5, 3)),
                 int'($urandom_range(12, 3)));
      else
        send_bit(w[i], w[i] ? 10 : 4, w[i] ? 5 : 11);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.din = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.rgb_data !== 24'h0 || bus.led_num !== 8'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: rgb=%h led=%h, expected 000000/00", bus.rgb_data, bus.led_num);
    end
    n_checks++;
    if ({bus.write, bus.frame_done, bus.error} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL reset_pulses: w/fd/err=%b%b%b, expected 000", bus.write, bus.frame_done, bus.error);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_busy: got %b, expected 0", bus.busy);
    end
    reset = 1'b1;
  endtask

  task automatic test_frame();
    logic [23:0] exp_data;
    logic [7:0]  exp_led;
    clear_logs();
    drive(1'b0, GAP);
    for (int k = 0; k < 8; k++) send_word(24'(32'h010203 * k), 1'b0);
    drive(1'b0, GAP);
    n_checks++;
    if (wr_q.size() != 8) begin
      n_fail++;
      $display("[TB] FAIL frame_writes: got %0d, expected 8", wr_q.size());
    end
    for (int k = 0; k < wr_q.size() && k < 8; k++) begin
      exp_data = 24'(32'h010203 * k);
      exp_led  = 8'(NUM_LEDS - 1 - k);
      n_checks++;
      if (wr_q[k].data !== exp_data || wr_q[k].led !== exp_led) begin
        n_fail++;
        $display("[TB] FAIL frame_word%0d: got %h@%0d, expected %h@%0d", k, wr_q[k].data, wr_q[k].led, exp_data, exp_led);
      end
    end
    n_checks++;
    if (err_q.size() != 0 || done_q.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL frame_status: errors=%0d done=%0d, expected 0 and 1", err_q.size(), done_q.size());
    end
  endtask

  task automatic test_latency();
    int exp_cyc;
    clear_logs();
    send_word(24'hA55A0F, 1'b0);
    exp_cyc = last_fall_edge + 2;
    drive(1'b0, GAP);
    n_checks++;
    if (wr_q.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL latency_writes: got %0d, expected 1", wr_q.size());
    end
    if (wr_q.size() >= 1) begin
      n_checks++;
      if (wr_q[0].cyc != exp_cyc) begin
        n_fail++;
        $display("[TB] FAIL latency_cycle: write at edge %0d, expected edge %0d", wr_q[0].cyc, exp_cyc);
      end
      n_checks++;
      if (wr_q[0].data !== 24'hA55A0F || wr_q[0].led !== 8'd7) begin
        n_fail++;
        $display("[TB] FAIL latency_word: got %h@%0d, expected a55a0f@7", wr_q[0].data, wr_q[0].led);
      end
    end
  endtask

  task automatic test_partial();
    clear_logs();
    for (int i = 0; i < 12; i++) send_bit(1'($urandom), 10, 5);
    drive(1'b0, GAP);
    n_checks++;
    if (wr_q.size() != 0 || err_q.size() != 1 || done_q.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL partial_counts: writes=%0d errors=%0d done=%0d, expected 0/1/1", wr_q.size(), err_q.size(), done_q.size());
    end else begin
      n_checks++;
      if (err_q[0] != done_q[0]) begin
        n_fail++;
        $display("[TB] FAIL partial_same_cycle: error at %0d, done at %0d", err_q[0], done_q[0]);
      end
    end
  endtask

  task automatic test_glitch();
    logic [23:0] w1, w2;
    w1 = 24'($urandom);
    w2 = 24'($urandom);
    clear_logs();
    drive(1'b1, 1);
    drive(1'b0, 20);
    send_word(w1, 1'b1);
    drive(1'b0, GAP);
    send_word(w2, 1'b1);
    drive(1'b0, GAP);
    n_checks++;
    if (err_q.size() != 1 || wr_q.size() != 1 || done_q.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL glitch_counts: errors=%0d writes=%0d done=%0d, expected 1/1/1", err_q.size(), wr_q.size(), done_q.size());
    end else begin
      n_checks++;
      if (wr_q[0].data !== w2 || wr_q[0].led !== 8'd7) begin
        n_fail++;
        $display("[TB] FAIL glitch_word: got %h@%0d, expected %h@7", wr_q[0].data, wr_q[0].led, w2);
      end
    end
  endtask

  task automatic test_overflow();
    logic [23:0] words[9];
    clear_logs();
    foreach (words[i]) words[i] = 24'($urandom);
    foreach (words[i]) send_word(words[i], 1'b1);
    drive(1'b0, GAP);
    n_checks++;
    if (wr_q.size() != 8 || err_q.size() != 1 || done_q.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL overflow_counts: writes=%0d errors=%0d done=%0d, expected 8/1/1", wr_q.size(), err_q.size(), done_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_checks++;
        if (wr_q[k].data !== words[k] || wr_q[k].led !== 8'(7 - k)) begin
          n_fail++;
          $display("[TB] FAIL overflow_word%0d: got %h@%0d, expected %h@%0d", k, wr_q[k].data, wr_q[k].led, words[k], 7 - k);
        end
      end
      n_checks++;
      if (!(err_q[0] > wr_q[7].cyc && err_q[0] < done_q[0])) begin
        n_fail++;
        $display("[TB] FAIL overflow_order: error at %0d, last write %0d, done %0d", err_q[0], wr_q[7].cyc, done_q[0]);
      end
    end
  endtask

  task automatic test_stuck();
    logic [23:0] w;
    w = 24'($urandom);
    clear_logs();
    drive(1'b1, 100);
    n_checks++;
    if (bus.busy !== 1'b0 || err_q.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL stuck_high: busy=%b errors=%0d, expected 0 and 1", bus.busy, err_q.size());
    end
    drive(1'b0, GAP);
    send_word(w, 1'b1);
    drive(1'b0, GAP);
    n_checks++;
    if (wr_q.size() != 1 || err_q.size() != 1 || done_q.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL stuck_recover: writes=%0d errors=%0d done=%0d, expected 1/1/1", wr_q.size(), err_q.size(), done_q.size());
    end else begin
      n_checks++;
      if (wr_q[0].data !== w || wr_q[0].led !== 8'd7) begin
        n_fail++;
        $display("[TB] FAIL stuck_word: got %h@%0d, expected %h@7", wr_q[0].data, wr_q[0].led, w);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [23:0] w0, w1, w3, w4;
    w0 = 24'($urandom);
    w1 = 24'($urandom) | 24'h1;
    w3 = 24'($urandom);
    w4 = 24'($urandom);
    send_word(w0, 1'b1);
    send_word(w1, 1'b1);
    for (int i = 0; i < 10; i++) send_bit(1'($urandom), 10, 5);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.rgb_data !== 24'h0 || bus.led_num !== 8'h0 || bus.busy !== 1'b0 ||
        {bus.write, bus.frame_done, bus.error} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL midreset_outputs: rgb=%h led=%h busy=%b, expected all zero", bus.rgb_data, bus.led_num, bus.busy);
    end
    reset = 1'b1;
    clear_logs();
    send_word(24'($urandom), 1'b1);
    drive(1'b0, GAP);
    send_word(w3, 1'b1);
    send_word(w4, 1'b1);
    drive(1'b0, GAP);
    n_checks++;
    if (wr_q.size() != 2 || err_q.size() != 0 || done_q.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL midreset_counts: writes=%0d errors=%0d done=%0d, expected 2/0/1", wr_q.size(), err_q.size(), done_q.size());
    end else begin
      n_checks++;
      if (wr_q[0].data !== w3 || wr_q[0].led !== 8'd7 || wr_q[1].data !== w4 || wr_q[1].led !== 8'd6) begin
        n_fail++;
        $display("[TB] FAIL midreset_words: got %h@%0d %h@%0d, expected %h@7 %h@6",
                 wr_q[0].data, wr_q[0].led, wr_q[1].data, wr_q[1].led, w3, w4);
      end
    end
  endtask

  // Frame model: first NUM_LEDS words are written from the last LED down,
  // surplus words cost one error, a trailing partial word costs one more.
  task automatic test_random();
    logic [23:0] words[$];
    int n, extra, exp_writes, exp_err;
    for (int f = 0; f < 4; f++) begin
      n = int'($urandom_range(10, 1));
      extra = ($urandom_range(1, 0) == 1) ? int'($urandom_range(23, 1)) : 0;
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(24'($urandom));
      clear_logs();
      foreach (words[i]) send_word(words[i], 1'b1);
      for (int i = 0; i < extra; i++)
        send_bit(1'($urandom), int'($urandom_range(14, 10)), int'($urandom_range(12, 3)));
      drive(1'b0, GAP);
      exp_writes = (n < NUM_LEDS) ? n : NUM_LEDS;
      exp_err = ((n > NUM_LEDS) ? 1 : 0) + ((extra != 0) ? 1 : 0);
      n_checks++;
      if (wr_q.size() != exp_writes || err_q.size() != exp_err || done_q.size() != 1) begin
        n_fail++;
        $display("[TB] FAIL random%0d_counts: writes=%0d errors=%0d done=%0d, expected %0d/%0d/1",
                 f, wr_q.size(), err_q.size(), done_q.size(), exp_writes, exp_err);
      end
      for (int k = 0; k < wr_q.size() && k < exp_writes; k++) begin
        n_checks++;
        if (wr_q[k].data !== words[k] || wr_q[k].led !== 8'(NUM_LEDS - 1 - k)) begin
          n_fail++;
          $display("[TB] FAIL random%0d_word%0d: got %h@%0d, expected %h@%0d",
                   f, k, wr_q[k].data, wr_q[k].led, words[k], NUM_LEDS - 1 - k);
        end
      end
    end
  endtask

  initial begin
    bus.din = 1'b0;
    test_reset();
    test_frame();
    test_latency();
    test_partial();
    test_glitch();
    test_overflow();
    test_stuck();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
